// File: rtl/multdiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multdiv_pkg                                                      |
// | Purpose  : Shared types for the iterative multiply/divide unit: FSM state  |
// |            encoding, operation encoding and the default datapath width.    |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package multdiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_MULT    = 2'd1,
    OP_DIV     = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_t;

endpackage
`default_nettype wire

// File: rtl/multdiv_iter_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multdiv_iter_core                                               |
// | Purpose  : Iterative datapath. Signed shift-add multiplier (one multiplier |
// |            bit per step) and, when MULTDIV_DIV_EN is defined, a restoring  |
// |            divider on operand magnitudes (one quotient bit per step).      |
// | Ports    : clk, reset        - clock, synchronous active-high reset        |
// |            i_load            - capture i_a/i_b and clear accumulators      |
// |            i_step            - perform one iteration                       |
// |            i_last            - current step is the final one               |
// |            i_is_div          - select divider result instead of product    |
// |            i_a, i_b          - signed operands                             |
// |            o_result, o_exc   - result/exception as they will be AFTER the  |
// |                                current step (registered by the caller)    |
// | Config   : MULTDIV_DIV_EN    - include the divider                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module multdiv_iter_core
  import multdiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic                  i_last,
  input  logic                  i_is_div,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_exc
);

  localparam int W = DATA_WIDTH;

  // ---------------------------------------------------------------- multiplier
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] w_pp;
  logic [2*W-1:0] w_acc_next;
  logic           w_mul_exc;

  // The multiplier is shifted arithmetically, so every step from bit W-1 on
  // sees the sign bit. Adding those and subtracting on the final step gives
  // the sign bit its -2^(W-1) weight for any step count >= W.
  assign w_pp       = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = i_last ? (r_acc - w_pp) : (r_acc + w_pp);

  // Overflow: the upper W+1 bits must all equal the result sign bit.
  assign w_mul_exc  = ~((&w_acc_next[2*W-1:W-1]) | ~(|w_acc_next[2*W-1:W-1]));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {{W{i_a[W-1]}}, i_a};
      r_mplier <= i_b;
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= {r_mplier[W-1], r_mplier[W-1:1]};
    end
  end

`ifdef MULTDIV_DIV_EN
  // ------------------------------------------------------------------- divider
  logic [W-1:0] r_rem;
  logic [W-1:0] r_quo;
  logic [W-1:0] r_dvsr;
  logic         r_neg;
  logic         r_ovf;
  logic [W:0]   w_shift;
  logic         w_fits;
  logic [W-1:0] w_rem_next;
  logic [W-1:0] w_quo_next;
  logic [W-1:0] w_abs_a;
  logic [W-1:0] w_abs_b;
  logic [W-1:0] w_div_res;

  assign w_abs_a    = i_a[W-1] ? (~i_a + 1'b1) : i_a;
  assign w_abs_b    = i_b[W-1] ? (~i_b + 1'b1) : i_b;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  assign w_shift    = {r_rem, r_quo[W-1]};
  assign w_fits     = (w_shift >= {1'b0, r_dvsr});
  assign w_rem_next = w_fits ? W'(w_shift - {1'b0, r_dvsr}) : w_shift[W-1:0];
  assign w_quo_next = {r_quo[W-2:0], w_fits};

  // Sign fix-up on the final quotient; MIN / -1 naturally yields MIN here.
  assign w_div_res  = r_neg ? (~w_quo_next + 1'b1) : w_quo_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvsr <= '0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (i_load) begin
      r_rem  <= '0;
      r_quo  <= w_abs_a;
      r_dvsr <= w_abs_b;
      r_neg  <= i_a[W-1] ^ i_b[W-1];
      r_ovf  <= (i_a == {1'b1, {(W-1){1'b0}}}) && (&i_b);
    end else if (i_step) begin
      r_rem  <= w_rem_next;
      r_quo  <= w_quo_next;
    end
  end

  assign o_result = i_is_div ? w_div_res : w_acc_next[W-1:0];
  assign o_exc    = i_is_div ? r_ovf     : w_mul_exc;
`else
  // Without the divider a division never reaches the iterative path.
  assign o_result = i_is_div ? '0   : w_acc_next[W-1:0];
  assign o_exc    = i_is_div ? 1'b1 : w_mul_exc;
`endif

endmodule
`default_nettype wire

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multdiv_ctrl                                                    |
// | Purpose  : Multi-cycle signed multiply/divide controller. Accepts a start  |
// |            pulse in IDLE, iterates ITERS cycles in BUSY, then presents the |
// |            result with a one-cycle PW latch strobe in DONE. Divide by zero,|
// |            illegal double starts and (without the divider) any divide go   |
// |            straight to DONE with result 0 and exception set.               |
// | Ports    : clk, reset                - clock, synchronous active-high reset|
// |            ctrl_MULT, ctrl_DIV       - one-cycle start pulses              |
// |            operandA, operandB        - signed operands                     |
// |            IR_in / IR_out            - issuing / held instruction word     |
// |            P_out                     - result                              |
// |            multdivException_out      - result exception flag               |
// |            pw_write_enable           - PW latch load strobe (DONE)         |
// |            stall                     - high whenever not IDLE              |
// | Config   : MULTDIV_DIV_EN            - include the divider path            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_WIDTH,
  parameter int ITERS      = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ctrl_MULT,
  input  logic                  ctrl_DIV,
  input  logic [DATA_WIDTH-1:0] operandA,
  input  logic [DATA_WIDTH-1:0] operandB,
  input  logic [31:0]           IR_in,
  output logic [31:0]           IR_out,
  output logic [DATA_WIDTH-1:0] P_out,
  output logic                  multdivException_out,
  output logic                  pw_write_enable,
  output logic                  stall
);

  localparam int                CNT_W    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ITERS - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  op_t                     r_op;
  op_t                     w_op;
  logic [CNT_W-1:0]        r_cnt;
  logic [31:0]             r_ir;
  logic [DATA_WIDTH-1:0]   r_p;
  logic                    r_exc;
  logic                    w_accept;
  logic                    w_fast;
  logic                    w_last;
  logic                    w_busy;
  logic                    w_div_ok;
  logic [DATA_WIDTH-1:0]   w_core_result;
  logic                    w_core_exc;

  assign w_busy = (r_state == BUSY);
  assign w_last = (r_cnt == LAST_CNT);

`ifdef MULTDIV_DIV_EN
  assign w_div_ok = (operandB != '0);
`else
  assign w_div_ok = 1'b0;
`endif

  // Decode the start request and whether it bypasses BUSY.
  always_comb begin
    w_op   = OP_NONE;
    w_fast = 1'b0;
    if (ctrl_MULT && ctrl_DIV) begin
      w_op   = OP_ILLEGAL;
      w_fast = 1'b1;
    end else if (ctrl_MULT) begin
      w_op   = OP_MULT;
    end else if (ctrl_DIV) begin
      w_op   = OP_DIV;
      w_fast = ~w_div_ok;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (ctrl_MULT || ctrl_DIV) begin
          w_accept     = 1'b1;
          w_state_next = w_fast ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (w_last) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ------------------------------------------------- counter and result regs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op  <= OP_NONE;
      r_cnt <= '0;
      r_ir  <= '0;
      r_p   <= '0;
      r_exc <= 1'b0;
    end else if (w_accept) begin
      r_op  <= w_op;
      r_cnt <= '0;
      r_ir  <= IR_in;
      if (w_fast) begin
        r_p   <= '0;
        r_exc <= 1'b1;
      end
    end else if (w_busy) begin
      r_cnt <= r_cnt + CNT_W'(1);
      // The core presents the post-step value, so the final step's result is
      // captured on the same edge that enters DONE.
      if (w_last) begin
        r_p   <= w_core_result;
        r_exc <= w_core_exc;
      end
    end
  end

  multdiv_iter_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_accept && !w_fast),
    .i_step   (w_busy),
    .i_last   (w_last),
    .i_is_div (r_op == OP_DIV),
    .i_a      (operandA),
    .i_b      (operandB),
    .o_result (w_core_result),
    .o_exc    (w_core_exc)
  );

  assign IR_out               = r_ir;
  assign P_out                = r_p;
  assign multdivException_out = r_exc;
  assign pw_write_enable      = (r_state == DONE);
  assign stall                = (r_state != IDLE);

endmodule
`default_nettype wire
